// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder_if
// Brief    : Bundles the feeder's job control, operand-buffer and array-edge
//            signals; master = feeder, slave = surrounding system.
// Revision : 1.0
// ============================================================================
interface systolic_feeder_if #(
  parameter int N  = 4,
  parameter int AW = 16
);
  logic             start;
  logic [AW-1:0]    k_len;
  logic [AW-1:0]    a_addr;
  logic [AW-1:0]    b_addr;
  logic             rd_en;
  logic [8*N-1:0]   a_rdata;
  logic [8*N-1:0]   b_rdata;
  logic [8*N-1:0]   west_data;
  logic [8*N-1:0]   north_data;
  logic             acc_clr;
  logic             busy;
  logic             done;

  modport master (
    input  start, k_len, a_rdata, b_rdata,
    output a_addr, b_addr, rd_en, west_data, north_data, acc_clr, busy, done
  );

  modport slave (
    output start, k_len, a_rdata, b_rdata,
    input  a_addr, b_addr, rd_en, west_data, north_data, acc_clr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : Streams K operand words into the west/north edges of an NxN
//            systolic MAC array with diagonal skew and zero fill.
//            Optional FEEDER_CYC_CNT_EN adds a saturating busy-cycle counter.
// Revision : 1.0
// ============================================================================
module systolic_feeder #(
  parameter int N  = 4,
  parameter int AW = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  systolic_feeder_if.master fb
`ifdef FEEDER_CYC_CNT_EN
  ,
  output logic [31:0]       cyc_cnt
`endif
);

  localparam int                c_FW         = $clog2(2 * N);
  localparam logic [c_FW-1:0]   c_FLUSH_LAST = c_FW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_klen;
  logic [AW-1:0]    r_k;
  logic [c_FW-1:0]  r_flush;
  logic             r_rd_vld;
  logic             w_feed_last;
  logic             w_flush_last;
  wire  [8*N-1:0]   w_west_bus;
  wire  [8*N-1:0]   w_north_bus;

  assign w_feed_last  = (r_k == r_klen - AW'(1));
  assign w_flush_last = (r_flush == c_FLUSH_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // K=0 has no data in flight, so the flush is empty and DONE follows CLEAR.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (fb.start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_klen == '0) ? S_DONE : S_FEED;
      S_FEED:  if (w_feed_last) w_next = S_FLUSH;
      S_FLUSH: if (w_flush_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_klen   <= '0;
      r_k      <= '0;
      r_flush  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      if (r_state == S_IDLE && fb.start) r_klen <= fb.k_len;
      r_k      <= (r_state == S_FEED && !w_feed_last) ? r_k + AW'(1) : '0;
      r_flush  <= (r_state == S_FLUSH) ? r_flush + c_FW'(1) : '0;
      r_rd_vld <= (r_state == S_FEED);
    end
  end

  assign fb.rd_en      = (r_state == S_FEED);
  assign fb.a_addr     = r_k;
  assign fb.b_addr     = r_k;
  assign fb.acc_clr    = (r_state == S_CLEAR);
  assign fb.busy       = (r_state != S_IDLE);
  assign fb.done       = (r_state == S_DONE);
  assign fb.west_data  = w_west_bus;
  assign fb.north_data = w_north_bus;

  // Lane g holds g+1 stages; stage 0 sits at the LSBs, the lane output at the MSBs.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [8*(gi+1)-1:0] r_wd;
    logic [8*(gi+1)-1:0] r_nd;
    logic [gi:0]         r_wt;
    logic [gi:0]         r_nt;
    logic [8*(gi+2)-1:0] w_wd_sh;
    logic [8*(gi+2)-1:0] w_nd_sh;
    logic [gi+1:0]       w_wt_sh;
    logic [gi+1:0]       w_nt_sh;

    assign w_wd_sh = {r_wd, fb.a_rdata[8*gi +: 8]};
    assign w_nd_sh = {r_nd, fb.b_rdata[8*gi +: 8]};
    assign w_wt_sh = {r_wt, r_rd_vld};
    assign w_nt_sh = {r_nt, r_rd_vld};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wd <= '0;
        r_nd <= '0;
        r_wt <= '0;
        r_nt <= '0;
      end else begin
        r_wd <= w_wd_sh[8*(gi+1)-1:0];
        r_nd <= w_nd_sh[8*(gi+1)-1:0];
        r_wt <= w_wt_sh[gi:0];
        r_nt <= w_nt_sh[gi:0];
      end
    end

    assign w_west_bus[8*gi +: 8]  = r_wt[gi] ? r_wd[8*gi +: 8] : 8'h00;
    assign w_north_bus[8*gi +: 8] = r_nt[gi] ? r_nd[8*gi +: 8] : 8'h00;
  end

`ifdef FEEDER_CYC_CNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 r_cyc_cnt <= '0;
    else if (r_state != S_IDLE && r_cyc_cnt != 32'hFFFF_FFFF) r_cyc_cnt <= r_cyc_cnt + 32'd1;
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Brief    : Directed + random jobs against a cycle-timed edge model and a
//            behavioural NxN MAC array fed from the DUT edges.
// Revision : 1.0
// ============================================================================
module tb_systolic_feeder;
  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   exp_cyc = 0;

  logic [7:0]  ma [N][DEPTH];
  logic [7:0]  mb [DEPTH][N];
  logic [7:0]  pa [N][N];
  logic [7:0]  pb [N][N];
  logic [31:0] acc [N][N];

  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .AW(AW)) fb ();

`ifdef FEEDER_CYC_CNT_EN
  logic [31:0] cyc_cnt;
  systolic_feeder #(.N(N), .AW(AW)) dut (.clk(clk), .rst(rst), .fb(fb), .cyc_cnt(cyc_cnt));
`else
  systolic_feeder #(.N(N), .AW(AW)) dut (.clk(clk), .rst(rst), .fb(fb));
`endif

  // Operand buffers: one-cycle registered read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fb.a_rdata <= '0;
      fb.b_rdata <= '0;
    end else if (fb.rd_en) begin
      for (int i = 0; i < N; i++) begin
        fb.a_rdata[8*i +: 8] <= ma[i][fb.a_addr[5:0]];
        fb.b_rdata[8*i +: 8] <= mb[fb.b_addr[5:0]][i];
      end
    end
  end

  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return fb.west_data[8*i +: 8];
    else        return pa[i][j-1];
  endfunction

  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return fb.north_data[8*j +: 8];
    else        return pb[i-1][j];
  endfunction

  // Behavioural systolic array: operands hop one PE per clock, every PE accumulates.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= fb.acc_clr ? 32'd0 : acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
        end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N-1:0] exp_west(int c, int K);
    logic [8*N-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int k = c - 4 - i;
      if (k >= 0 && k < K) v[8*i +: 8] = ma[i][k];
    end
    return v;
  endfunction

  function automatic logic [8*N-1:0] exp_north(int c, int K);
    logic [8*N-1:0] v = '0;
    for (int j = 0; j < N; j++) begin
      int k = c - 4 - j;
      if (k >= 0 && k < K) v[8*j +: 8] = mb[k][j];
    end
    return v;
  endfunction

  task automatic fill(input bit pattern);
    for (int k = 0; k < DEPTH; k++)
      for (int x = 0; x < N; x++) begin
        ma[x][k] = pattern ? 8'(16*x + k + 1) : 8'($urandom_range(0, 255));
        mb[k][x] = pattern ? 8'(16*k + x + 1) : 8'($urandom_range(0, 255));
      end
  endtask

  task automatic chk_edges(input int c, input int K);
    chk($sformatf("west c%0d", c),  fb.west_data,  exp_west(c, K));
    chk($sformatf("north c%0d", c), fb.north_data, exp_north(c, K));
  endtask

  // One job: cycle 0 is the cycle whose closing edge accepts start.
  task automatic run_job(input int K, input int glitch_c, input int rst_c);
    int          D;
    logic [31:0] ref_sum;
    D = (K == 0) ? 2 : K + 2*N + 2;
    @(posedge clk); #1;
    fb.start = 1'b1;
    fb.k_len = AW'(K);
    chk("busy c0", fb.busy, 0);
    chk("done c0", fb.done, 0);
    chk_edges(0, K);
    for (int c = 1; c <= D; c++) begin
      @(posedge clk); #1;
      fb.start = (c == glitch_c);
      fb.k_len = (c == glitch_c) ? AW'(K + 5) : AW'(K);
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        chk("rst busy", fb.busy, 0);
        chk("rst rd_en", fb.rd_en, 0);
        chk("rst addr", fb.a_addr, 0);
        chk("rst west", fb.west_data, 0);
        chk("rst north", fb.north_data, 0);
`ifdef FEEDER_CYC_CNT_EN
        chk("rst cyc_cnt", cyc_cnt, 0);
`endif
        @(posedge clk); #1;
        rst      = 1'b0;
        fb.start = 1'b0;
        exp_cyc  = 0;
        for (int w = 0; w < D; w++) begin
          @(posedge clk); #1;
          chk("abort done", fb.done, 0);
          chk("abort busy", fb.busy, 0);
        end
        return;
      end
      chk($sformatf("acc_clr c%0d", c), fb.acc_clr, (c == 1));
      chk($sformatf("busy c%0d", c), fb.busy, 1);
      chk($sformatf("done c%0d", c), fb.done, (c == D));
      chk($sformatf("rd_en c%0d", c), fb.rd_en, (c >= 2 && c <= K + 1));
      if (c >= 2 && c <= K + 1) begin
        chk($sformatf("a_addr c%0d", c), fb.a_addr, c - 2);
        chk($sformatf("b_addr c%0d", c), fb.b_addr, c - 2);
      end
      chk_edges(c, K);
      if (c == D) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            ref_sum = 0;
            for (int k = 0; k < K; k++) ref_sum += 32'(ma[i][k]) * 32'(mb[k][j]);
            chk($sformatf("sum%0d%0d K%0d", i, j, K), acc[i][j], ref_sum);
          end
`ifdef FEEDER_CYC_CNT_EN
        chk("cyc_cnt", cyc_cnt, exp_cyc + D - 1);
`endif
      end
    end
    exp_cyc += D;
    fb.start = 1'b0;
  endtask

  initial begin
    fb.start = 1'b0;
    fb.k_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", fb.busy, 0);
    chk("reset done", fb.done, 0);
    chk("reset acc_clr", fb.acc_clr, 0);
    chk("reset rd_en", fb.rd_en, 0);
    chk("reset a_addr", fb.a_addr, 0);
    chk("reset b_addr", fb.b_addr, 0);
    chk("reset west", fb.west_data, 0);
    chk("reset north", fb.north_data, 0);
    rst = 1'b0;

    fill(1'b1); run_job(8, 0, 0);
    fill(1'b0); run_job(0, 0, 0);
    fill(1'b0); run_job(5, 4, 0);
    fill(1'b0); run_job(8, 0, 6);
    fill(1'b0); run_job(2, 0, 0);
    fill(1'b0); run_job(3, 0, 0);
    fill(1'b0); run_job(3, 0, 0);
    for (int r = 0; r < 3; r++) begin
      fill(1'b0);
      run_job($urandom_range(1, 40), 0, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", fb.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
